// File: rtl/iter_divider_pkg.sv
// Package riscv_pkg: shared types and constants for the iterative RV32M divider.
//   div_op_e     : operation encoding as it arrives from decode (00 DIV .. 11 REMU)
//   div_state_e  : divider FSM states
//   DIV_BY_ZERO_Q: quotient returned for a zero divisor (all ones, sliced to XLEN)
package riscv_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } div_state_e;

  // Wide enough for any XLEN up to 64; users slice the low XLEN bits.
  localparam int unsigned MAX_XLEN = 64;
  localparam logic [MAX_XLEN-1:0] DIV_BY_ZERO_Q = '1;

  // DIV and REM interpret operands as two's complement (op[0] == 0).
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder (op[1] == 1).
  function automatic logic is_rem_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Interface iter_divider_if: request/response bundle between control and the divider.
//   master (control side) drives start, flush, op, dividend, divisor, rd_in and
//   observes busy, wr_en, rd_out, result. slave is the divider side.
interface iter_divider_if
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  div_op_e         op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [4:0]      rd_in;
  logic            busy;
  logic            wr_en;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, op, dividend, divisor, rd_in,
    input  busy, wr_en, rd_out, result
  );

  modport slave (
    input  start, flush, op, dividend, divisor, rd_in,
    output busy, wr_en, rd_out, result
  );
endinterface

// File: rtl/iter_divider_div_step.sv
// Module div_step: one combinational restoring-division iteration.
//   rem_i/quo_i : current partial remainder and the quotient/dividend shift register
//   divisor_i   : unsigned divisor magnitude
//   rem_o/quo_o : state after shifting in one dividend bit and trying the subtract
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // rem < divisor holds between steps, so the shifted value is below 2*divisor and
  // the MSB of the XLEN+1-bit difference is a reliable "went negative" flag.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign trial   = shifted - {1'b0, divisor_i};

  assign rem_o = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], ~trial[XLEN]};
endmodule

// File: rtl/iter_divider.sv
// Module iter_divider: multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU).
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of iter_divider_if
//                start/op/dividend/divisor/rd_in launch an op (sampled in IDLE only),
//                flush aborts, busy stalls the PC, wr_en pulses once with result/rd_out.
// Normal ops take XLEN CALC cycles plus SIGN and DONE; divide-by-zero and the signed
// overflow case skip straight to DONE.
module iter_divider
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  iter_divider_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  div_op_e         op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand conditioning for the launch cycle.
  logic            sgn_op;
  logic            dd_neg;
  logic            dv_neg;
  logic [XLEN-1:0] abs_dd;
  logic [XLEN-1:0] abs_dv;
  logic            div_zero;
  logic            sgn_ovf;

  assign sgn_op   = is_signed_op(bus.op);
  assign dd_neg   = sgn_op & bus.dividend[XLEN-1];
  assign dv_neg   = sgn_op & bus.divisor[XLEN-1];
  // INT_MIN negates to itself, which is the correct unsigned magnitude.
  assign abs_dd   = dd_neg ? -bus.dividend : bus.dividend;
  assign abs_dv   = dv_neg ? -bus.divisor  : bus.divisor;
  assign div_zero = (bus.divisor == '0);
  assign sgn_ovf  = sgn_op && (bus.dividend == INT_MIN) && (bus.divisor == '1);

  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= DIV;
      rd_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    unique case (state_q)
      IDLE: begin
        // A simultaneous flush suppresses the launch.
        if (bus.start && !bus.flush) begin
          op_d    = bus.op;
          rd_d    = bus.rd_in;
          count_d = '0;
          if (div_zero) begin
            result_d = is_rem_op(bus.op) ? bus.dividend : DIV_BY_ZERO_Q[XLEN-1:0];
            state_d  = DONE;
          end else if (sgn_ovf) begin
            result_d = is_rem_op(bus.op) ? '0 : INT_MIN;
            state_d  = DONE;
          end else begin
            rem_d     = '0;
            quo_d     = abs_dd;
            dvs_d     = abs_dv;
            neg_quo_d = dd_neg ^ dv_neg;
            neg_rem_d = dd_neg;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + CW'(1);
          if (count_q == CW'(XLEN - 1)) begin
            state_d = SIGN;
          end
        end
      end
      SIGN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          // Sign flags are only ever set for signed ops, so unsigned ops pass through.
          if (is_rem_op(op_q)) begin
            result_d = neg_rem_q ? -rem_q : rem_q;
          end else begin
            result_d = neg_quo_q ? -quo_q : quo_q;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.wr_en  = (state_q == DONE) && !bus.flush;
  assign bus.rd_out = rd_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  iter_divider_if #(.XLEN(32)) bus ();

  iter_divider #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the last observed operation.
  int          lat;
  int          pulses;
  int          busy_cycles;
  logic [31:0] res;
  logic [4:0]  rdo;
  logic [31:0] prev_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a start at a negedge so the next posedge is E0, then returns at the
  // negedge following E0.
  task automatic launch(input div_op_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic fl);
    @(negedge clk);
    bus.op = o; bus.dividend = a; bus.divisor = b; bus.rd_in = rd;
    bus.start = 1'b1; bus.flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Iteration k samples the negedge after edge E_k; drives set here are seen at E_{k+1}.
  task automatic observe(input int s1, input int s2, input int fk,
                         input logic [31:0] alt_a, input logic [31:0] alt_b);
    lat = -1; pulses = 0; busy_cycles = 0; res = '0; rdo = '0;
    for (int k = 0; k < 75; k++) begin
      if (bus.busy) busy_cycles++;
      if (bus.wr_en) begin
        pulses++;
        if (lat < 0) begin
          lat = k; res = bus.result; rdo = bus.rd_out;
        end
      end
      bus.start = (k == s1) || (k == s2);
      bus.flush = (k == fk);
      if (k == s1) begin
        bus.dividend = alt_a; bus.divisor = alt_b;
      end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic run(input string tag, input div_op_e o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    launch(o, a, b, 5'd7, 1'b0);
    observe(-1, -1, -1, '0, '0);
    $display("[TB] %s op=%0d a=%h b=%h result=%h lat=%0d", tag, o, a, b, res, lat);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_busy"}, 32'(busy_cycles), 32'(exp_lat + 1));
    chk({tag, "_hold"}, bus.result, exp);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = DIV;
    bus.dividend = '0; bus.divisor = '0; bus.rd_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr", 32'(bus.wr_en), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_rd", 32'(bus.rd_out), 32'd0);
    rst_n = 1'b1;

    // 1: DIVU 100/7 with rd 5
    launch(DIVU, 32'd100, 32'd7, 5'd5, 1'b0);
    observe(-1, -1, -1, '0, '0);
    $display("[TB] t1 DIVU 100/7 result=%0d rd=%0d lat=%0d busy=%0d", res, rdo, lat, busy_cycles);
    chk("t1_res", res, 32'd14);
    chk("t1_rd", 32'(rdo), 32'd5);
    chk("t1_lat", 32'(lat), 32'd33);
    chk("t1_busy", 32'(busy_cycles), 32'd34);
    chk("t1_pulses", 32'(pulses), 32'd1);

    // 2: sign handling
    run("div_m7_2",   DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
    run("rem_m7_2",   REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
    run("remu_7_2",   REMU, 32'd7,         32'd2,        32'd1,         33);
    run("div_7_m2",   DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run("rem_7_m2",   REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    run("rem_min_3",  REM,  32'h8000_0000, 32'd3,        32'hFFFF_FFFE, 33);
    run("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 33);
    run("divu_min_m1",DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        33);

    // 3: fast paths
    run("div_by0",    DIV,  32'd55,        32'd0,        32'hFFFF_FFFF, 0);
    run("remu_by0",   REMU, 32'd123,       32'd0,        32'd123,       0);
    run("rem_by0",    REM,  32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 0);
    run("div_ovf",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run("rem_ovf",    REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        0);

    // 4: starts at E5 and E10 while busy are ignored
    launch(DIVU, 32'd1000, 32'd10, 5'd3, 1'b0);
    observe(4, 9, -1, 32'd5, 32'd1);
    $display("[TB] t4 DIVU 1000/10 extra starts result=%0d pulses=%0d", res, pulses);
    chk("t4_res", res, 32'd100);
    chk("t4_pulses", 32'(pulses), 32'd1);
    chk("t4_busy", 32'(busy_cycles), 32'd34);
    chk("t4_rd", 32'(rdo), 32'd3);

    // 5: flush at E12 aborts; result keeps the old value
    prev_res = bus.result;
    launch(DIV, 32'd20, 32'd3, 5'd4, 1'b0);
    observe(-1, -1, 11, '0, '0);
    $display("[TB] t5 flush at E12 busy=%0d pulses=%0d result=%h", busy_cycles, pulses, bus.result);
    chk("t5_busy", 32'(busy_cycles), 32'd12);
    chk("t5_pulses", 32'(pulses), 32'd0);
    chk("t5_hold", bus.result, prev_res);
    run("t5_after", DIVU, 32'd50, 32'd5, 32'd10, 33);

    // start together with flush in IDLE launches nothing
    launch(DIVU, 32'd9, 32'd3, 5'd2, 1'b1);
    observe(-1, -1, -1, '0, '0);
    $display("[TB] start+flush busy=%0d pulses=%0d", busy_cycles, pulses);
    chk("sf_busy", 32'(busy_cycles), 32'd0);
    chk("sf_pulses", 32'(pulses), 32'd0);

    // 6: async reset mid-CALC
    launch(DIVU, 32'd1000, 32'd7, 5'd9, 1'b0);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    $display("[TB] t6 async reset busy=%0d wr=%0d result=%h rd=%0d", bus.busy, bus.wr_en, bus.result, bus.rd_out);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_wr", 32'(bus.wr_en), 32'd0);
    chk("t6_result", bus.result, 32'd0);
    chk("t6_rd", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("t6_after", DIVU, 32'd1000, 32'd7, 32'd142, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
